// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types, grid defaults and direction helper for the snake step engine
package snake_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_QUERY  = 3'd1,
        S_COMMIT = 3'd2,
        S_DONE   = 3'd3,
        S_DEAD   = 3'd4
    } step_state_t;

    localparam int GRID_W_DEF = 32;
    localparam int GRID_H_DEF = 24;

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        return ((a == UP)   && (b == DOWN))  || ((a == DOWN)  && (b == UP)) ||
               ((a == LEFT) && (b == RIGHT)) || ((a == RIGHT) && (b == LEFT));
    endfunction

endpackage

// File: rtl/snake_next_pos.sv
// rtl/snake_next_pos.sv - combinational next head cell; SNAKE_WALL_WRAP_EN selects edge wrap instead of wall death
module snake_next_pos
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF,
    parameter int X_BITS = 5,
    parameter int Y_BITS = 5
) (
    input  logic [X_BITS-1:0] head_x,
    input  logic [Y_BITS-1:0] head_y,
    input  dir_t              dir,
    output logic [X_BITS-1:0] nxt_x,
    output logic [Y_BITS-1:0] nxt_y,
    output logic              off_grid
);

    localparam logic [X_BITS-1:0] X_MAX = X_BITS'(GRID_W - 1);
    localparam logic [Y_BITS-1:0] Y_MAX = Y_BITS'(GRID_H - 1);
`ifdef SNAKE_WALL_WRAP_EN
    localparam logic WALL = 1'b0;
`else
    localparam logic WALL = 1'b1;
`endif

    // Edge cells always produce the wrapped cell; WALL decides whether leaving is fatal.
    always_comb begin
        nxt_x    = head_x;
        nxt_y    = head_y;
        off_grid = 1'b0;
        case (dir)
            UP: begin
                if (head_y == '0) begin
                    nxt_y    = Y_MAX;
                    off_grid = WALL;
                end else begin
                    nxt_y = head_y - Y_BITS'(1);
                end
            end
            DOWN: begin
                if (head_y == Y_MAX) begin
                    nxt_y    = '0;
                    off_grid = WALL;
                end else begin
                    nxt_y = head_y + Y_BITS'(1);
                end
            end
            LEFT: begin
                if (head_x == '0) begin
                    nxt_x    = X_MAX;
                    off_grid = WALL;
                end else begin
                    nxt_x = head_x - X_BITS'(1);
                end
            end
            default: begin
                if (head_x == X_MAX) begin
                    nxt_x    = '0;
                    off_grid = WALL;
                end else begin
                    nxt_x = head_x + X_BITS'(1);
                end
            end
        endcase
    end

endmodule

// File: rtl/snake_step.sv
// rtl/snake_step.sv - snake movement step engine on the tick handshake; SNAKE_WALL_WRAP_EN enables edge wrap
module snake_step
    import snake_pkg::*;
#(
    parameter int GRID_W   = GRID_W_DEF,
    parameter int GRID_H   = GRID_H_DEF,
    parameter int X_BITS   = 5,
    parameter int Y_BITS   = 5,
    parameter int LEN_BITS = 8,
    parameter int INIT_LEN = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_tick,
    output logic                o_tick_done,
    input  logic                i_up,
    input  logic                i_down,
    input  logic                i_left,
    input  logic                i_right,
    input  logic                i_restart,
    input  logic [X_BITS-1:0]   i_food_x,
    input  logic [Y_BITS-1:0]   i_food_y,
    output logic                o_query_valid,
    output logic [X_BITS-1:0]   o_query_x,
    output logic [Y_BITS-1:0]   o_query_y,
    input  logic                i_query_ack,
    input  logic                i_query_hit,
    output logic                o_advance,
    output logic                o_grow,
    output logic [X_BITS-1:0]   o_head_x,
    output logic [Y_BITS-1:0]   o_head_y,
    output logic [LEN_BITS-1:0] o_length,
    output logic                o_dead
);

    localparam logic [X_BITS-1:0]   CENTRE_X = X_BITS'(GRID_W / 2);
    localparam logic [Y_BITS-1:0]   CENTRE_Y = Y_BITS'(GRID_H / 2);
    localparam logic [LEN_BITS-1:0] LEN_INIT = LEN_BITS'(INIT_LEN);

    step_state_t         state_q, state_d;
    dir_t                dir_q, dir_d, pend_q, pend_d, btn;
    logic                btn_any, starting, off_grid, is_food;
    logic [X_BITS-1:0]   step_x, nxt_x_d, head_x_d;
    logic [Y_BITS-1:0]   step_y, nxt_y_d, head_y_d;
    logic [LEN_BITS-1:0] length_d;
    logic                query_valid_d, advance_d, grow_d, done_d, dead_d;

    snake_next_pos #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H),
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_next_pos (
        .head_x   (o_head_x),
        .head_y   (o_head_y),
        .dir      (pend_q),
        .nxt_x    (step_x),
        .nxt_y    (step_y),
        .off_grid (off_grid)
    );

    assign starting = (state_q == S_IDLE) && i_tick && !i_restart;
    assign is_food  = (o_query_x == i_food_x) && (o_query_y == i_food_y);

    // Reversal is judged against the direction that will be committed this cycle.
    always_comb begin
        dir_d   = starting ? pend_q : dir_q;
        btn     = RIGHT;
        btn_any = 1'b1;
        if (i_up)         btn = UP;
        else if (i_down)  btn = DOWN;
        else if (i_left)  btn = LEFT;
        else if (i_right) btn = RIGHT;
        else              btn_any = 1'b0;
        pend_d = pend_q;
        if (i_restart) begin
            dir_d  = RIGHT;
            pend_d = RIGHT;
        end else if (btn_any && !is_opposite(btn, dir_d)) begin
            pend_d = btn;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (i_restart) begin
            state_d = i_tick ? S_DONE : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:   if (i_tick) state_d = off_grid ? S_DONE : S_QUERY;
                S_QUERY:  if (i_query_ack) state_d = i_query_hit ? S_DONE : S_COMMIT;
                S_COMMIT: state_d = S_DONE;
                S_DONE:   if (!i_tick) state_d = o_dead ? S_DEAD : S_IDLE;
                S_DEAD:   if (i_tick) state_d = S_DONE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // Next values of the registered outputs, decoded from the state being entered.
    always_comb begin
        query_valid_d = (state_d == S_QUERY);
        advance_d     = (state_d == S_COMMIT);
        grow_d        = advance_d && is_food;
        done_d        = (state_d == S_DONE);
        nxt_x_d       = starting ? step_x : o_query_x;
        nxt_y_d       = starting ? step_y : o_query_y;
        head_x_d      = o_head_x;
        head_y_d      = o_head_y;
        length_d      = o_length;
        dead_d        = o_dead;
        if (i_restart) begin
            head_x_d = CENTRE_X;
            head_y_d = CENTRE_Y;
            length_d = LEN_INIT;
            dead_d   = 1'b0;
        end else begin
            if (starting && off_grid) dead_d = 1'b1;
            if ((state_q == S_QUERY) && i_query_ack && i_query_hit) dead_d = 1'b1;
            if (advance_d) begin
                head_x_d = o_query_x;
                head_y_d = o_query_y;
                if (grow_d && (o_length != '1)) length_d = o_length + LEN_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q         <= RIGHT;
            pend_q        <= RIGHT;
            o_query_valid <= 1'b0;
            o_query_x     <= CENTRE_X;
            o_query_y     <= CENTRE_Y;
            o_advance     <= 1'b0;
            o_grow        <= 1'b0;
            o_tick_done   <= 1'b0;
            o_head_x      <= CENTRE_X;
            o_head_y      <= CENTRE_Y;
            o_length      <= LEN_INIT;
            o_dead        <= 1'b0;
        end else begin
            dir_q         <= dir_d;
            pend_q        <= pend_d;
            o_query_valid <= query_valid_d;
            o_query_x     <= nxt_x_d;
            o_query_y     <= nxt_y_d;
            o_advance     <= advance_d;
            o_grow        <= grow_d;
            o_tick_done   <= done_d;
            o_head_x      <= head_x_d;
            o_head_y      <= head_y_d;
            o_length      <= length_d;
            o_dead        <= dead_d;
        end
    end

endmodule

// File: tb/tb_snake_step.sv
// tb/tb_snake_step.sv - directed self-checking bench for snake_step (expectations follow SNAKE_WALL_WRAP_EN)
module tb_snake_step;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_tick = 1'b0, i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic       i_restart = 1'b0, i_query_ack = 1'b0, i_query_hit = 1'b0;
    logic [4:0] i_food_x = 5'd0, i_food_y = 5'd0;
    logic       o_tick_done, o_query_valid, o_advance, o_grow, o_dead;
    logic [4:0] o_query_x, o_query_y, o_head_x, o_head_y;
    logic [7:0] o_length;

    int n_cmp = 0;
    int n_err = 0;
    int hx, hy, exp_len, seg;

    always #5 clk = ~clk;

    snake_step dut (
        .clk(clk), .rst(rst), .i_tick(i_tick), .o_tick_done(o_tick_done),
        .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
        .i_restart(i_restart), .i_food_x(i_food_x), .i_food_y(i_food_y),
        .o_query_valid(o_query_valid), .o_query_x(o_query_x), .o_query_y(o_query_y),
        .i_query_ack(i_query_ack), .i_query_hit(i_query_hit),
        .o_advance(o_advance), .o_grow(o_grow), .o_head_x(o_head_x), .o_head_y(o_head_y),
        .o_length(o_length), .o_dead(o_dead)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic press(input int d);
        i_up    = (d == 0);
        i_down  = (d == 1);
        i_left  = (d == 2);
        i_right = (d == 3);
        @(negedge clk);
        {i_up, i_down, i_left, i_right} = 4'b0000;
    endtask

    task automatic restart();
        i_restart = 1'b1;
        @(negedge clk);
        i_restart = 1'b0;
        check("restart_head_x", 32'(o_head_x), 16);
        check("restart_head_y", 32'(o_head_y), 12);
        check("restart_length", 32'(o_length), 3);
        check("restart_dead", 32'(o_dead), 0);
    endtask

    // One full tick handshake: query at (qx,qy), ack after `delay` extra cycles.
    task automatic step(input int qx, input int qy, input int delay, input bit hit, input bit grow);
        i_tick = 1'b1;
        @(negedge clk);
        for (int d = 0; d <= delay; d++) begin
            check("query_valid", 32'(o_query_valid), 1);
            check("query_x", 32'(o_query_x), qx);
            check("query_y", 32'(o_query_y), qy);
            check("done_in_query", 32'(o_tick_done), 0);
            check("adv_in_query", 32'(o_advance), 0);
            if (d == delay) begin
                i_query_ack = 1'b1;
                i_query_hit = hit;
            end
            @(negedge clk);
        end
        i_query_ack = 1'b0;
        i_query_hit = 1'b0;
        if (!hit) begin
            check("advance", 32'(o_advance), 1);
            check("grow", 32'(o_grow), 32'(grow));
            check("commit_head_x", 32'(o_head_x), qx);
            check("commit_head_y", 32'(o_head_y), qy);
            check("done_in_commit", 32'(o_tick_done), 0);
            @(negedge clk);
        end else begin
            check("hit_dead", 32'(o_dead), 1);
        end
        check("advance_off", 32'(o_advance), 0);
        check("query_off", 32'(o_query_valid), 0);
        check("tick_done", 32'(o_tick_done), 1);
        @(negedge clk);
        check("tick_done_held", 32'(o_tick_done), 1);
        i_tick = 1'b0;
        @(negedge clk);
        check("tick_done_drop", 32'(o_tick_done), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tick_done", 32'(o_tick_done), 0);
        check("rst_query_valid", 32'(o_query_valid), 0);
        check("rst_advance", 32'(o_advance), 0);
        check("rst_grow", 32'(o_grow), 0);
        check("rst_dead", 32'(o_dead), 0);
        check("rst_head_x", 32'(o_head_x), 16);
        check("rst_head_y", 32'(o_head_y), 12);
        check("rst_length", 32'(o_length), 3);

        // basic step right with immediate ack
        i_food_x = 5'd5; i_food_y = 5'd5;
        step(17, 12, 0, 1'b0, 1'b0);
        check("idle_no_done", 32'(o_tick_done), 0);

        // reversal is ignored, a perpendicular press is taken
        restart();
        press(2);
        step(17, 12, 0, 1'b0, 1'b0);
        restart();
        press(0);
        step(16, 11, 0, 1'b0, 1'b0);
        check("up_head_y", 32'(o_head_y), 11);

        // growth, then drive the length into saturation around a square
        restart();
        i_food_x = 5'd17; i_food_y = 5'd12;
        step(17, 12, 0, 1'b0, 1'b1);
        check("grow_len4", 32'(o_length), 4);
        hx = 17; hy = 12; exp_len = 4;
        for (int k = 0; k < 254; k++) begin
            seg = (k / 4) % 4;
            case (seg)
                0: begin press(3); hx = hx + 1; end
                1: begin press(1); hy = hy + 1; end
                2: begin press(2); hx = hx - 1; end
                default: begin press(0); hy = hy - 1; end
            endcase
            i_food_x = 5'(hx); i_food_y = 5'(hy);
            step(hx, hy, 0, 1'b0, 1'b1);
            if (exp_len < 255) exp_len++;
        end
        check("len_saturated", 32'(o_length), 32'(exp_len));
        check("len_255", 32'(o_length), 255);

        // restart while a query is pending, with ack in the same cycle
        i_food_x = 5'd0; i_food_y = 5'd0;
        restart();
        i_tick = 1'b1;
        @(negedge clk);
        check("rq_query_valid", 32'(o_query_valid), 1);
        i_restart = 1'b1; i_query_ack = 1'b1;
        @(negedge clk);
        i_restart = 1'b0; i_query_ack = 1'b0;
        check("rq_no_advance", 32'(o_advance), 0);
        check("rq_query_off", 32'(o_query_valid), 0);
        check("rq_done", 32'(o_tick_done), 1);
        check("rq_head_x", 32'(o_head_x), 16);
        check("rq_head_y", 32'(o_head_y), 12);
        check("rq_length", 32'(o_length), 3);
        check("rq_dead", 32'(o_dead), 0);
        @(negedge clk);
        check("rq_no_advance2", 32'(o_advance), 0);
        check("rq_done_held", 32'(o_tick_done), 1);
        i_tick = 1'b0;
        @(negedge clk);
        check("rq_done_drop", 32'(o_tick_done), 0);

        // delayed hit kills the snake; later ticks are still acknowledged
        step(17, 12, 4, 1'b1, 1'b0);
        check("hit_head_x", 32'(o_head_x), 16);
        check("hit_head_y", 32'(o_head_y), 12);
        i_tick = 1'b1;
        @(negedge clk);
        check("dead_tick_done", 32'(o_tick_done), 1);
        check("dead_no_query", 32'(o_query_valid), 0);
        check("dead_no_advance", 32'(o_advance), 0);
        check("dead_head_x", 32'(o_head_x), 16);
        i_tick = 1'b0;
        @(negedge clk);
        check("dead_done_drop", 32'(o_tick_done), 0);
        check("dead_still", 32'(o_dead), 1);

        // march to the right edge and step off it
        restart();
        for (int x = 17; x <= 31; x++) step(x, 12, 0, 1'b0, 1'b0);
        check("edge_head_x", 32'(o_head_x), 31);
`ifdef SNAKE_WALL_WRAP_EN
        step(0, 12, 0, 1'b0, 1'b0);
        check("wrap_head_x", 32'(o_head_x), 0);
        check("wrap_alive", 32'(o_dead), 0);
`else
        i_tick = 1'b1;
        @(negedge clk);
        check("wall_done", 32'(o_tick_done), 1);
        check("wall_no_query", 32'(o_query_valid), 0);
        check("wall_no_advance", 32'(o_advance), 0);
        check("wall_dead", 32'(o_dead), 1);
        check("wall_head_x", 32'(o_head_x), 31);
        i_tick = 1'b0;
        @(negedge clk);
        check("wall_done_drop", 32'(o_tick_done), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
